// File: rtl/bg_scroll_controller.sv
// bg_scroll_controller
// Per-frame background scroll controller. It turns a WASD key code into
// pre-wrapped scroll offsets for the background renderer. The scroll speed
// ramps up while a key is held and ramps down when the key is released.
// A collision freezes the scroll for a fixed number of frames.

module bg_scroll_controller #(
    parameter int MAX_SPEED     = 4,
    parameter int ACCEL_FRAMES  = 8,
    parameter int FREEZE_FRAMES = 60,
    parameter int X_WRAP        = 640,
    parameter int Y_WRAP        = 480
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       collided,
    output logic [9:0] x_offset,
    output logic [9:0] y_offset,
    output logic [1:0] heading,
    output logic [2:0] speed,
    output logic       frozen
);

    localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int FRZ_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
    localparam logic [FRZ_W-1:0] FRZ_LOAD = FRZ_W'(FREEZE_FRAMES - 1);
    localparam logic [2:0]       MAX_SPD  = 3'(MAX_SPEED);
    localparam logic [10:0]      X_W      = 11'(X_WRAP);
    localparam logic [10:0]      Y_W      = 11'(Y_WRAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [FRZ_W-1:0] frz, frz_n;
    logic [9:0]       x_n, y_n;
    logic [1:0]       heading_n;
    logic [2:0]       speed_n;
    logic             frozen_n;

    logic             key_valid;
    logic [1:0]       key_dir;

    // Offset plus speed, folded back into 0..wrap-1.
    function automatic logic [9:0] wrap_inc(input logic [9:0] off,
                                            input logic [2:0] spd,
                                            input logic [10:0] wrap);
        logic [10:0] n;
        n = {1'b0, off} + {8'd0, spd};
        if (n >= wrap) n = n - wrap;
        return n[9:0];
    endfunction

    // Offset minus speed, borrowing one full wrap when it would go negative.
    function automatic logic [9:0] wrap_dec(input logic [9:0] off,
                                            input logic [2:0] spd,
                                            input logic [10:0] wrap);
        logic [10:0] n;
        if ({1'b0, off} >= {8'd0, spd}) n = {1'b0, off} - {8'd0, spd};
        else                            n = {1'b0, off} + wrap - {8'd0, spd};
        return n[9:0];
    endfunction

    // Decode the four movement keys into a direction; anything else is "no key".
    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'b00;
        case (keycode)
            8'h1A:   key_dir = 2'b00;
            8'h16:   key_dir = 2'b01;
            8'h07:   key_dir = 2'b10;
            8'h04:   key_dir = 2'b11;
            default: key_valid = 1'b0;
        endcase
    end

    // Next-state and next-output logic for the scroll state machine.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        frz_n     = frz;
        x_n       = x_offset;
        y_n       = y_offset;
        heading_n = heading;
        speed_n   = speed;
        frozen_n  = frozen;

        case (state)
            IDLE: begin
                if (collided) begin
                    state_n  = HIT;
                    speed_n  = 3'd0;
                    acc_n    = '0;
                    frz_n    = FRZ_LOAD;
                    frozen_n = 1'b1;
                end else if (key_valid) begin
                    state_n   = MOVE;
                    heading_n = key_dir;
                    speed_n   = 3'd1;
                    acc_n     = '0;
                end
            end

            MOVE: begin
                if (collided) begin
                    state_n  = HIT;
                    speed_n  = 3'd0;
                    acc_n    = '0;
                    frz_n    = FRZ_LOAD;
                    frozen_n = 1'b1;
                end else begin
                    if (key_valid) heading_n = key_dir;

                    case (heading)
                        2'b00:   y_n = wrap_dec(y_offset, speed, Y_W);
                        2'b01:   y_n = wrap_inc(y_offset, speed, Y_W);
                        2'b10:   x_n = wrap_inc(x_offset, speed, X_W);
                        default: x_n = wrap_dec(x_offset, speed, X_W);
                    endcase

                    if (acc == ACC_LAST) begin
                        acc_n = '0;
                        if (key_valid) begin
                            speed_n = (speed >= MAX_SPD) ? MAX_SPD : speed + 3'd1;
                        end else begin
                            speed_n = speed - 3'd1;
                            if (speed == 3'd1) state_n = IDLE;
                        end
                    end else begin
                        acc_n = acc + ACC_W'(1);
                    end
                end
            end

            HIT: begin
                if (frz == '0) begin
                    state_n  = IDLE;
                    frozen_n = 1'b0;
                end else begin
                    frz_n = frz - FRZ_W'(1);
                end
            end

            default: begin
                state_n  = IDLE;
                speed_n  = 3'd0;
                acc_n    = '0;
                frz_n    = '0;
                frozen_n = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared at once by Reset.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            acc      <= '0;
            frz      <= '0;
            x_offset <= 10'd0;
            y_offset <= 10'd0;
            heading  <= 2'b00;
            speed    <= 3'd0;
            frozen   <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            frz      <= frz_n;
            x_offset <= x_n;
            y_offset <= y_n;
            heading  <= heading_n;
            speed    <= speed_n;
            frozen   <= frozen_n;
        end
    end

endmodule
